// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the load/store path.
// One transaction is in flight at a time; data has priority, fetch is protected
// from starvation, and fetch responses invalidated by a flush are dropped.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_v_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_adr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [31:0]     if_rdata_o,
    input  logic            d_req_i,
    input  logic [XLEN-1:0] d_adr_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_wdata_i,
    input  logic [2:0]      d_size_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [2:0]      mem_size_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t          state, state_nxt;
    logic [3:0]      starve_cnt;
    logic            kill;
    logic            owner_fetch;   // 1 = fetch owns the transaction, 0 = data
    logic            fetch_eff;
    logic            both_req;
    logic            fetch_win;
    logic            data_win;
    logic [XLEN-1:0] adr_hold;
    logic [XLEN-1:0] wdata_hold;
    logic            we_hold;
    logic [2:0]      size_hold;
    logic            rsp_done;

    // Counter increment that never passes the starvation limit.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt >= STARVE_LIM) ? STARVE_LIM : cnt + 4'd1;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Arbitration, next state and memory-side handshake outputs.
    always_comb begin
        state_nxt   = state;
        fetch_eff   = if_req_i & ~flush_v_i;
        both_req    = fetch_eff & d_req_i;
        fetch_win   = 1'b0;
        data_win    = 1'b0;
        rsp_done    = 1'b0;
        mem_req_o   = 1'b0;
        mem_adr_o   = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_size_o  = 3'b000;
        case (state)
            IDLE: begin
                if (both_req) begin
                    if (starve_cnt == STARVE_LIM) fetch_win = 1'b1;
                    else                          data_win  = 1'b1;
                end else if (d_req_i) begin
                    data_win = 1'b1;
                end else if (fetch_eff) begin
                    fetch_win = 1'b1;
                end
                if (fetch_win || data_win) state_nxt = REQ;
            end
            REQ: begin
                mem_req_o   = 1'b1;
                mem_adr_o   = adr_hold;
                mem_we_o    = we_hold;
                mem_wdata_o = wdata_hold;
                mem_size_o  = size_hold;
                if (mem_gnt_i) state_nxt = RSP;
            end
            RSP: begin
                if (mem_rvalid_i) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if_gnt_o = fetch_win;
        d_gnt_o  = data_win;
    end

    // Control state: starvation counter, owner, kill flag and response strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt  <= 4'd0;
            kill        <= 1'b0;
            owner_fetch <= 1'b0;
            if_rvalid_o <= 1'b0;
            d_rvalid_o  <= 1'b0;
        end else begin
            if_rvalid_o <= 1'b0;
            d_rvalid_o  <= 1'b0;
            if (fetch_win) begin
                starve_cnt  <= 4'd0;
                owner_fetch <= 1'b1;
                kill        <= 1'b0;
            end else if (data_win) begin
                owner_fetch <= 1'b0;
                kill        <= 1'b0;
                if (both_req) starve_cnt <= sat_inc(starve_cnt);
            end
            if ((state == REQ || state == RSP) && owner_fetch && flush_v_i)
                kill <= 1'b1;
            if (rsp_done) begin
                if (!owner_fetch) d_rvalid_o  <= 1'b1;
                else if (!kill)   if_rvalid_o <= 1'b1;
            end
        end
    end

    // Request fields captured at grant so the requester is free to move on.
    always_ff @(posedge clk) begin
        if (fetch_win) begin
            adr_hold   <= if_adr_i;
            we_hold    <= 1'b0;
            wdata_hold <= '0;
            size_hold  <= 3'b010;
        end else if (data_win) begin
            adr_hold   <= d_adr_i;
            we_hold    <= d_we_i;
            wdata_hold <= d_wdata_i;
            size_hold  <= d_size_i;
        end
    end

    // Response data registers; they keep the last delivered value between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata_o <= '0;
            d_rdata_o  <= '0;
        end else if (rsp_done) begin
            if (!owner_fetch)  d_rdata_o  <= mem_rdata_i;
            else if (!kill)    if_rdata_o <= mem_rdata_i[31:0];
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a behavioural memory, a scoreboard of expected
// responses keyed by grant order, and directed scenarios for the main use cases.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            flush_v_i;
    logic            if_req_i;
    logic [XLEN-1:0] if_adr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [31:0]     if_rdata_o;
    logic            d_req_i;
    logic [XLEN-1:0] d_adr_i;
    logic            d_we_i;
    logic [XLEN-1:0] d_wdata_i;
    logic [2:0]      d_size_i;
    logic            d_gnt_o;
    logic            d_rvalid_o;
    logic [XLEN-1:0] d_rdata_o;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_adr_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [2:0]      mem_size_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset), .flush_v_i(flush_v_i),
        .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_adr_i(d_adr_i), .d_we_i(d_we_i),
        .d_wdata_i(d_wdata_i), .d_size_i(d_size_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic        fetch;
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] rdata;
        logic        killed;
    } exp_t;

    exp_t q[$];
    bit   gnt_log[$];
    exp_t e;
    bit   pend;
    bit   mgnt;
    int   n_chk;
    int   n_fail;
    int   gnt_dly;
    int   rsp_dly;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of the behavioural memory (reads and write acks return the same word).
    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h80)  return 32'h0000_0013;
        if (a == 32'h200) return 32'h1234_5678;
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Memory model: grants after gnt_dly cycles of request, answers rsp_dly cycles later.
    // It knows nothing of the arbiter's reset, so an abandoned transaction still answers.
    initial begin : memory
        int  req_wait;
        int  rsp_wait;
        bit  busy;
        logic [31:0] adr_q;
        req_wait = 0; rsp_wait = 0; busy = 0; adr_q = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (busy) begin
                if (rsp_wait >= rsp_dly) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = memval(adr_q);
                    busy         = 0;
                end else begin
                    rsp_wait++;
                end
            end else if (mem_req_o) begin
                if (req_wait >= gnt_dly) begin
                    mem_gnt_i = 1'b1;
                    adr_q     = mem_adr_o;
                    busy      = 1;
                    rsp_wait  = 0;
                    req_wait  = 0;
                end else begin
                    req_wait++;
                end
            end else begin
                req_wait = 0;
            end
        end
    end

    // Scoreboard: sampled one time unit before each rising edge.
    always begin
        @(negedge clk); #4;
        if (reset) begin
            q.delete();
            pend = 0;
            mgnt = 0;
        end else begin
            if (pend) begin
                pend = 0;
                if (q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    if (e.killed) begin
                        chk("rsp_killed_if", if_rvalid_o, 0);
                        chk("rsp_killed_d", d_rvalid_o, 0);
                    end else if (e.fetch) begin
                        chk("rsp_if_vld", if_rvalid_o, 1);
                        chk("rsp_if_d_quiet", d_rvalid_o, 0);
                        chk("rsp_if_data", if_rdata_o, e.rdata);
                    end else begin
                        chk("rsp_d_vld", d_rvalid_o, 1);
                        chk("rsp_d_if_quiet", if_rvalid_o, 0);
                        chk("rsp_d_data", d_rdata_o, e.rdata);
                    end
                end
            end else begin
                chk("no_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
            end
            if (mgnt && mem_rvalid_i) begin
                pend = 1;
                mgnt = 0;
            end else if (flush_v_i && q.size() > 0) begin
                if (q[0].fetch) begin
                    e = q[0];
                    e.killed = 1'b1;
                    q[0] = e;
                end
            end
            if (mem_req_o) begin
                if (q.size() == 0) begin
                    chk("mem_req_orphan", 1, 0);
                end else begin
                    chk("mem_adr", mem_adr_o, q[$].adr);
                    chk("mem_we", mem_we_o, q[$].we);
                    chk("mem_wdata", mem_wdata_o, q[$].wdata);
                    chk("mem_size", mem_size_o, q[$].size);
                end
                if (mem_gnt_i) mgnt = 1;
            end
            if (if_gnt_o || d_gnt_o) begin
                chk("gnt_excl", if_gnt_o & d_gnt_o, 0);
                e.fetch  = if_gnt_o;
                e.adr    = if_gnt_o ? if_adr_i : d_adr_i;
                e.we     = if_gnt_o ? 1'b0 : d_we_i;
                e.wdata  = if_gnt_o ? 32'h0 : d_wdata_i;
                e.size   = if_gnt_o ? 3'b010 : d_size_i;
                e.rdata  = memval(e.adr);
                e.killed = 1'b0;
                q.push_back(e);
                gnt_log.push_back(if_gnt_o);
            end
        end
    end

    // Wait for the requested grant, then release and scramble the requester inputs.
    task automatic wait_gnt(input bit fetch);
        bit got;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (fetch ? if_gnt_o : d_gnt_o) got = 1;
            step();
        end
        chk(fetch ? "if_gnt_seen" : "d_gnt_seen", got, 1);
        if_req_i  = 1'b0;
        d_req_i   = 1'b0;
        if_adr_i  = $urandom;
        d_adr_i   = $urandom;
        d_wdata_i = $urandom;
        d_we_i    = 1'($urandom_range(0, 1));
        d_size_i  = 3'($urandom_range(0, 7));
    endtask

    task automatic issue_fetch(input logic [31:0] adr);
        if_req_i = 1'b1;
        if_adr_i = adr;
        wait_gnt(1);
    endtask

    task automatic issue_data(input logic we, input logic [31:0] adr,
                              input logic [31:0] wdata, input logic [2:0] size);
        d_req_i   = 1'b1;
        d_adr_i   = adr;
        d_we_i    = we;
        d_wdata_i = wdata;
        d_size_i  = size;
        wait_gnt(0);
    endtask

    // Cycles from the cycle after grant until the strobe appears.
    task automatic wait_rsp(input bit fetch, output int n);
        bit got;
        got = 0;
        n = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (fetch ? if_rvalid_o : d_rvalid_o) got = 1;
            else begin step(); n++; end
        end
        chk(fetch ? "if_rsp_seen" : "d_rsp_seen", got, 1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, mem_req_o, mem_we_o}, 0);
        chk({tag, "_if_rdata"}, if_rdata_o, 0);
        chk({tag, "_d_rdata"}, d_rdata_o, 0);
        chk({tag, "_mem_adr"}, mem_adr_o, 0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
        chk({tag, "_mem_size"}, mem_size_o, 0);
    endtask

    initial begin : main
        int n;
        n_chk = 0; n_fail = 0; gnt_dly = 0; rsp_dly = 0;
        reset = 1'b1; flush_v_i = 1'b0;
        if_req_i = 1'b0; if_adr_i = '0;
        d_req_i = 1'b0; d_adr_i = '0; d_we_i = 1'b0; d_wdata_i = '0; d_size_i = 3'b000;
        repeat (3) step();
        chk_quiet("reset");
        reset = 1'b0;
        step();

        // Fetch only, minimum latency
        if_req_i = 1'b1; if_adr_i = 32'h80;
        #1 chk("fo_gnt_c0", if_gnt_o, 1);
        step();
        if_req_i = 1'b0; if_adr_i = 32'hFFFF_FFF0;
        chk("fo_mem_req_c1", mem_req_o, 1);
        chk("fo_mem_adr_c1", mem_adr_o, 32'h80);
        chk("fo_mem_we_c1", mem_we_o, 0);
        wait_rsp(1, n);
        chk("fo_latency", n, 2);
        chk("fo_rdata", if_rdata_o, 32'h13);
        step();

        // Store with a delayed memory grant
        gnt_dly = 2;
        issue_data(1'b1, 32'h1000, 32'hDEAD_BEEF, 3'b010);
        n = 0;
        while (mem_req_o && n < 20) begin n++; step(); end
        chk("st_req_cycles", n, 3);
        wait_rsp(0, n);
        chk("st_ack_data", d_rdata_o, memval(32'h1000));
        gnt_dly = 0;
        step();

        // Contention with starvation guard
        gnt_log.delete();
        if_req_i = 1'b1; if_adr_i = 32'h400;
        d_req_i = 1'b1; d_adr_i = 32'h500; d_we_i = 1'b0; d_wdata_i = 32'h0; d_size_i = 3'b010;
        for (int i = 0; i < 300 && gnt_log.size() < 10; i++) step();
        if_req_i = 1'b0; d_req_i = 1'b0;
        chk("cont_gnt_count", gnt_log.size(), 10);
        for (int i = 0; i < 10 && i < gnt_log.size(); i++)
            chk($sformatf("cont_order_%0d", i), gnt_log[i], (i == 4 || i == 9) ? 1 : 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        step();

        // Flush while a fetch is in RSP
        rsp_dly = 2;
        issue_fetch(32'h200);
        step();
        flush_v_i = 1'b1;
        step();
        flush_v_i = 1'b0;
        n = 0;
        repeat (8) begin if (if_rvalid_o) n++; step(); end
        chk("fl_no_rvalid", n, 0);
        chk("fl_drained", q.size(), 0);
        rsp_dly = 0;
        issue_fetch(32'h84);
        wait_rsp(1, n);
        chk("fl_next_latency", n, 2);
        chk("fl_next_rdata", if_rdata_o, memval(32'h84));
        step();

        // Flush in IDLE masks the fetch request for that cycle only
        if_req_i = 1'b1; if_adr_i = 32'h88; flush_v_i = 1'b1;
        #1 chk("fi_no_gnt", if_gnt_o, 0);
        step();
        flush_v_i = 1'b0;
        #1 chk("fi_gnt", if_gnt_o, 1);
        step();
        if_req_i = 1'b0;
        wait_rsp(1, n);
        chk("fi_rdata", if_rdata_o, memval(32'h88));
        step();

        // Reset while in RSP; the memory answers afterwards
        rsp_dly = 3;
        issue_data(1'b0, 32'h300, 32'h0, 3'b010);
        step();
        reset = 1'b1;
        step();
        chk_quiet("rr");
        reset = 1'b0;
        n = 0;
        repeat (8) begin if (if_rvalid_o || d_rvalid_o) n++; step(); end
        chk("rr_stray", n, 0);
        rsp_dly = 0;
        issue_fetch(32'h80);
        wait_rsp(1, n);
        chk("rr_next_latency", n, 2);
        chk("rr_next_rdata", if_rdata_o, 32'h13);
        repeat (3) step();
        chk("sb_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch stage and the exe-stage load/store path.
- Sits between the core's fetch and data requesters and the memory.
- Arbitrates one transaction at a time, with data priority and a fetch starvation guard.
- Sequences the memory request/grant/response handshake and routes each response to its owner.
- Drops fetch responses invalidated by a pipeline flush.

Parameters:
- XLEN, 32, data/address width
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- flush_v_i  in  1  pipeline flush (branch/exception redirect)
- if_req_i  in  1  fetch request
- if_adr_i  in  XLEN  fetch address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse)
- if_rdata_o  out  32  fetched instruction
- d_req_i  in  1  data request
- d_adr_i  in  XLEN  data address
- d_we_i  in  1  1 = store
- d_wdata_i  in  XLEN  store data
- d_size_i  in  3  access size code, passed through unchanged
- d_gnt_o  out  1  data request accepted (1-cycle pulse)
- d_rvalid_o  out  1  data response valid (1-cycle pulse; load data or store ack)
- d_rdata_o  out  XLEN  load data
- mem_req_o  out  1  memory request
- mem_adr_o  out  XLEN  memory address
- mem_we_o  out  1  memory write
- mem_wdata_o  out  XLEN  memory write data
- mem_size_o  out  3  memory access size
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid (returned for reads and writes)
- mem_rdata_i  in  XLEN  memory read data

Behaviour:
- Reset: state IDLE, starve_cnt=0, kill=0, owner=data, all outputs 0.
- Reset mid-transaction abandons the transaction; later mem_rvalid_i is ignored.
- FSM has three states: IDLE, REQ, RSP.
- IDLE, arbitration:
  - Effective fetch request is if_req_i & ~flush_v_i.
  - Only data requests: data wins.
  - Only fetch requests: fetch wins.
  - Both request: data wins, unless starve_cnt==STARVE_MAX, in which case fetch wins.
  - Winner's gnt_o pulses in the same cycle.
  - Winner's adr/we/wdata/size are latched into hold registers; for fetch, we=0, wdata=0, size=3'b010.
  - owner is latched; state goes to REQ.
  - The requester may change its inputs after the grant.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when both request and data wins.
  - Clears when fetch wins.
  - Holds otherwise.
- REQ:
  - mem_req_o=1; mem_* driven from the hold registers, stable until grant.
  - On mem_gnt_i, go to RSP; mem_req_o drops the following cycle.
- RSP:
  - mem_req_o=0.
  - On mem_rvalid_i, go to IDLE and register the response one cycle later:
    - owner=data: d_rvalid_o=1, d_rdata_o=mem_rdata_i (also on stores).
    - owner=fetch and kill=0: if_rvalid_o=1, if_rdata_o=mem_rdata_i[31:0].
    - owner=fetch and kill=1: no rvalid.
- mem_rvalid_i in IDLE or REQ is ignored.
- rdata outputs hold their last value when rvalid is low.
- Only one transaction is outstanding; no new grant is given until the FSM returns to IDLE.
- Back-to-back: a new grant is possible in the cycle the previous response is presented.
- Kill:
  - Set when flush_v_i=1, owner=fetch and state is REQ or RSP.
  - Cleared on arbitration in IDLE.
  - The killed transaction still completes on the memory side.
- Minimum latency, request to rvalid_o:
  - Cycle 0: grant.
  - Cycle 1: mem_req_o with mem_gnt_i.
  - Cycle 2: mem_rvalid_i.
  - Cycle 3: rvalid_o.
- Memory stalls extend REQ/RSP indefinitely; there is no timeout.

Test Plan:
- Fetch only:
  - Stimulus: if_req_i=1, if_adr_i=0x80; memory grants immediately and returns 0x00000013 next cycle.
  - Response: if_gnt_o at cycle 0; mem_adr_o=0x80 with mem_we_o=0 at cycle 1; if_rvalid_o=1 with if_rdata_o=0x00000013 at cycle 3.
- Store:
  - Stimulus: d_req_i=1, d_we_i=1, d_adr_i=0x1000, d_wdata_i=0xDEADBEEF, d_size_i=3'b010; mem_gnt_i delayed 2 cycles.
  - Response: mem_req_o high for 3 cycles with stable fields; d_rvalid_o pulse after mem_rvalid_i; no if_* activity.
- Contention with starvation:
  - Stimulus: if_req_i and d_req_i both held high, STARVE_MAX=4.
  - Response: grant order is d,d,d,d,if,d,d,d,d,if; starve_cnt returns to 0 after each fetch grant.
- Flush:
  - Stimulus: fetch granted; flush_v_i=1 in RSP; mem_rvalid_i with 0x12345678.
  - Response: no if_rvalid_o; the FSM returns to IDLE; the next fetch completes normally.
- Flush in IDLE:
  - Stimulus: if_req_i=1 and flush_v_i=1 in the same cycle.
  - Response: no if_gnt_o that cycle; granted the next cycle once flush_v_i=0.
- Reset in RSP:
  - Stimulus: assert reset while in RSP; mem_rvalid_i arrives after reset.
  - Response: all outputs 0; stray mem_rvalid_i produces no rvalid; the next request behaves as from reset.
